id_ex_stage_reg: RTL and testbench

- ID/EX pipeline register that sits directly downstream of the instruction-decode control unit in the 32-bit integer RISC-V core.
- Captures the decoder's control bundle, register operands, immediate, PC and register addresses every cycle, and presents them to the EX stage.
- Contains the load-use hazard detector: it inserts a bubble and stalls IF/ID when needed.
- Handles EX-resolved branch/jump flushes and whole-pipe holds requested by the memory stage.

---
 rtl/id_ex_stage_reg.sv | 178 +++++++++++++++++
 tb/tb_id_ex_stage_reg.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection, EX flush and memory-stage hold.
// Optional bubble statistics counter enabled by defining ID_EX_BUBBLE_STATS_EN.
module id_ex_stage_reg #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5,
  parameter int CTRL_W     = 14
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [CTRL_W-1:0]     ctrl_id,
  input  logic [2:0]            fun3_id,
  input  logic [XLEN-1:0]       pc_id,
  input  logic [XLEN-1:0]       rs1_data_id,
  input  logic [XLEN-1:0]       rs2_data_id,
  input  logic [XLEN-1:0]       imm_id,
  input  logic [REG_ADDR_W-1:0] rs1_addr_id,
  input  logic [REG_ADDR_W-1:0] rs2_addr_id,
  input  logic [REG_ADDR_W-1:0] rd_addr_id,
  input  logic                  valid_id,
  input  logic                  flush,
  input  logic                  hold,
  output logic [CTRL_W-1:0]     ctrl_ex,
  output logic [2:0]            fun3_ex,
  output logic [XLEN-1:0]       pc_ex,
  output logic [XLEN-1:0]       rs1_data_ex,
  output logic [XLEN-1:0]       rs2_data_ex,
  output logic [XLEN-1:0]       imm_ex,
  output logic [REG_ADDR_W-1:0] rs1_addr_ex,
  output logic [REG_ADDR_W-1:0] rs2_addr_ex,
  output logic [REG_ADDR_W-1:0] rd_addr_ex,
  output logic                  valid_ex,
  output logic                  stall_if_id,
  output logic [31:0]           bubble_count
);

  localparam int D_MEM_R_BIT = CTRL_W - 1;

  typedef enum logic [1:0] {
    ACT_LOAD   = 2'd0,
    ACT_HOLD   = 2'd1,
    ACT_BUBBLE = 2'd2
  } action_e;

  logic    ex_is_load_s;
  logic    rs1_match_s;
  logic    rs2_match_s;
  logic    hazard_s;
  action_e action_s;

  logic [CTRL_W-1:0]     ctrl_nxt_s;
  logic [2:0]            fun3_nxt_s;
  logic [XLEN-1:0]       pc_nxt_s;
  logic [XLEN-1:0]       rs1_data_nxt_s;
  logic [XLEN-1:0]       rs2_data_nxt_s;
  logic [XLEN-1:0]       imm_nxt_s;
  logic [REG_ADDR_W-1:0] rs1_addr_nxt_s;
  logic [REG_ADDR_W-1:0] rs2_addr_nxt_s;
  logic [REG_ADDR_W-1:0] rd_addr_nxt_s;
  logic                  valid_nxt_s;

  // Load-use detection: rs2 is compared for every opcode, so I-type may stall falsely.
  always_comb begin
    ex_is_load_s = valid_ex & ctrl_ex[D_MEM_R_BIT] & (rd_addr_ex != {REG_ADDR_W{1'b0}});
    rs1_match_s  = (rd_addr_ex == rs1_addr_id);
    rs2_match_s  = (rd_addr_ex == rs2_addr_id);
    hazard_s     = ex_is_load_s & valid_id & (rs1_match_s | rs2_match_s);
    stall_if_id  = hazard_s & ~flush & ~hold;
  end

  // Per-edge action: flush beats hold, hold beats a hazard bubble.
  always_comb begin
    action_s = ACT_LOAD;
    if (flush) begin
      action_s = ACT_BUBBLE;
    end else if (hold) begin
      action_s = ACT_HOLD;
    end else if (hazard_s) begin
      action_s = ACT_BUBBLE;
    end else begin
      action_s = ACT_LOAD;
    end
  end

  // Next-state selection for every EX-side register.
  always_comb begin
    ctrl_nxt_s     = ctrl_ex;
    fun3_nxt_s     = fun3_ex;
    pc_nxt_s       = pc_ex;
    rs1_data_nxt_s = rs1_data_ex;
    rs2_data_nxt_s = rs2_data_ex;
    imm_nxt_s      = imm_ex;
    rs1_addr_nxt_s = rs1_addr_ex;
    rs2_addr_nxt_s = rs2_addr_ex;
    rd_addr_nxt_s  = rd_addr_ex;
    valid_nxt_s    = valid_ex;
    case (action_s)
      ACT_LOAD: begin
        ctrl_nxt_s     = valid_id ? ctrl_id : {CTRL_W{1'b0}};
        fun3_nxt_s     = fun3_id;
        pc_nxt_s       = pc_id;
        rs1_data_nxt_s = rs1_data_id;
        rs2_data_nxt_s = rs2_data_id;
        imm_nxt_s      = imm_id;
        rs1_addr_nxt_s = rs1_addr_id;
        rs2_addr_nxt_s = rs2_addr_id;
        rd_addr_nxt_s  = rd_addr_id;
        valid_nxt_s    = valid_id;
      end
      ACT_HOLD: begin
        valid_nxt_s = valid_ex;
      end
      ACT_BUBBLE: begin
        // A bubble is fully zeroed so it can never write, access memory or branch.
        ctrl_nxt_s     = {CTRL_W{1'b0}};
        fun3_nxt_s     = 3'd0;
        pc_nxt_s       = {XLEN{1'b0}};
        rs1_data_nxt_s = {XLEN{1'b0}};
        rs2_data_nxt_s = {XLEN{1'b0}};
        imm_nxt_s      = {XLEN{1'b0}};
        rs1_addr_nxt_s = {REG_ADDR_W{1'b0}};
        rs2_addr_nxt_s = {REG_ADDR_W{1'b0}};
        rd_addr_nxt_s  = {REG_ADDR_W{1'b0}};
        valid_nxt_s    = 1'b0;
      end
      default: begin
        ctrl_nxt_s  = {CTRL_W{1'b0}};
        valid_nxt_s = 1'b0;
      end
    endcase
  end

  // EX-side pipeline registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ctrl_ex     <= {CTRL_W{1'b0}};
      fun3_ex     <= 3'd0;
      pc_ex       <= {XLEN{1'b0}};
      rs1_data_ex <= {XLEN{1'b0}};
      rs2_data_ex <= {XLEN{1'b0}};
      imm_ex      <= {XLEN{1'b0}};
      rs1_addr_ex <= {REG_ADDR_W{1'b0}};
      rs2_addr_ex <= {REG_ADDR_W{1'b0}};
      rd_addr_ex  <= {REG_ADDR_W{1'b0}};
      valid_ex    <= 1'b0;
    end else begin
      ctrl_ex     <= ctrl_nxt_s;
      fun3_ex     <= fun3_nxt_s;
      pc_ex       <= pc_nxt_s;
      rs1_data_ex <= rs1_data_nxt_s;
      rs2_data_ex <= rs2_data_nxt_s;
      imm_ex      <= imm_nxt_s;
      rs1_addr_ex <= rs1_addr_nxt_s;
      rs2_addr_ex <= rs2_addr_nxt_s;
      rd_addr_ex  <= rd_addr_nxt_s;
      valid_ex    <= valid_nxt_s;
    end
  end

`ifdef ID_EX_BUBBLE_STATS_EN
  logic [31:0] bubble_count_r;

  // Saturating bubble counter; a simultaneous flush and hazard counts once.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bubble_count_r <= 32'd0;
    end else if ((action_s == ACT_BUBBLE) && (bubble_count_r != 32'hFFFF_FFFF)) begin
      bubble_count_r <= bubble_count_r + 32'd1;
    end else begin
      bubble_count_r <= bubble_count_r;
    end
  end

  assign bubble_count = bubble_count_r;
`else
  assign bubble_count = 32'd0;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Directed self-checking bench for id_ex_stage_reg; bubble_count expectations
// follow whether ID_EX_BUBBLE_STATS_EN is defined.
module tb_id_ex_stage_reg;

  logic        clk;
  logic        reset_n;
  logic [13:0] ctrl_id;
  logic [2:0]  fun3_id;
  logic [31:0] pc_id, rs1_data_id, rs2_data_id, imm_id;
  logic [4:0]  rs1_addr_id, rs2_addr_id, rd_addr_id;
  logic        valid_id, flush, hold;
  logic [13:0] ctrl_ex;
  logic [2:0]  fun3_ex;
  logic [31:0] pc_ex, rs1_data_ex, rs2_data_ex, imm_ex;
  logic [4:0]  rs1_addr_ex, rs2_addr_ex, rd_addr_ex;
  logic        valid_ex, stall_if_id;
  logic [31:0] bubble_count;

  int n_assert = 0;
  int n_fail   = 0;
  int bubbles  = 0;

  localparam logic [13:0] C_ADDI = 14'h0C98;
  localparam logic [13:0] C_LW   = 14'h2290;
  localparam logic [13:0] C_ADD  = 14'h0200;

  id_ex_stage_reg dut (
    .clk(clk), .reset_n(reset_n), .ctrl_id(ctrl_id), .fun3_id(fun3_id), .pc_id(pc_id),
    .rs1_data_id(rs1_data_id), .rs2_data_id(rs2_data_id), .imm_id(imm_id),
    .rs1_addr_id(rs1_addr_id), .rs2_addr_id(rs2_addr_id), .rd_addr_id(rd_addr_id),
    .valid_id(valid_id), .flush(flush), .hold(hold), .ctrl_ex(ctrl_ex), .fun3_ex(fun3_ex),
    .pc_ex(pc_ex), .rs1_data_ex(rs1_data_ex), .rs2_data_ex(rs2_data_ex), .imm_ex(imm_ex),
    .rs1_addr_ex(rs1_addr_ex), .rs2_addr_ex(rs2_addr_ex), .rd_addr_ex(rd_addr_ex),
    .valid_ex(valid_ex), .stall_if_id(stall_if_id), .bubble_count(bubble_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] bc_exp(input int n);
`ifdef ID_EX_BUBBLE_STATS_EN
    return n;
`else
    return 32'd0;
`endif
  endfunction

  task automatic drive(input logic [13:0] c, input logic [2:0] f3, input logic [31:0] pc,
                       input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm,
                       input logic [4:0] a1, input logic [4:0] a2, input logic [4:0] rd,
                       input logic v);
    ctrl_id = c; fun3_id = f3; pc_id = pc; rs1_data_id = d1; rs2_data_id = d2;
    imm_id = imm; rs1_addr_id = a1; rs2_addr_id = a2; rd_addr_id = rd; valid_id = v;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0; flush = 1'b0; hold = 1'b0;
    drive(14'h0, 3'd0, 32'h0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0, 5'd0, 1'b0);
    tick(); tick();
    chk("rst_ctrl", ctrl_ex, 32'h0);
    chk("rst_valid", valid_ex, 32'h0);
    chk("rst_pc", pc_ex, 32'h0);
    chk("rst_stall", stall_if_id, 32'h0);
    chk("rst_bc", bubble_count, 32'h0);
    reset_n = 1'b1;

    // ADDI x5,x0,7
    drive(C_ADDI, 3'd0, 32'h100, 32'h0, 32'h1234, 32'd7, 5'd0, 5'd7, 5'd5, 1'b1);
    tick();
    chk("addi_ctrl", ctrl_ex, 32'h0C98);
    chk("addi_imm", imm_ex, 32'd7);
    chk("addi_rd", rd_addr_ex, 32'd5);
    chk("addi_valid", valid_ex, 32'd1);
    chk("addi_pc", pc_ex, 32'h100);
    chk("addi_rs2d", rs2_data_ex, 32'h1234);

    // LW x6,4(x1) then dependent ADD x7,x6,x1
    drive(C_LW, 3'd2, 32'h104, 32'h40, 32'h0, 32'd4, 5'd1, 5'd4, 5'd6, 1'b1);
    tick();
    chk("lw_ctrl", ctrl_ex, 32'h2290);
    chk("lw_fun3", fun3_ex, 32'd2);
    drive(C_ADD, 3'd0, 32'h108, 32'h0, 32'h55, 32'd0, 5'd6, 5'd1, 5'd7, 1'b1);
    #1;
    chk("lu_stall", stall_if_id, 32'd1);
    tick(); bubbles++;
    chk("bub_valid", valid_ex, 32'd0);
    chk("bub_ctrl", ctrl_ex, 32'h0);
    chk("bub_rd", rd_addr_ex, 32'd0);
    chk("bub_rs1a", rs1_addr_ex, 32'd0);
    chk("bub_stall", stall_if_id, 32'd0);
    chk("bub_bc", bubble_count, bc_exp(bubbles));
    tick();
    chk("add_ctrl", ctrl_ex, 32'h0200);
    chk("add_pc", pc_ex, 32'h108);
    chk("add_valid", valid_ex, 32'd1);

    // LW x0 followed by ADD x7,x0,x0: no stall
    drive(C_LW, 3'd2, 32'h10C, 32'h0, 32'h0, 32'd0, 5'd1, 5'd0, 5'd0, 1'b1);
    tick();
    drive(C_ADD, 3'd0, 32'h110, 32'h0, 32'h0, 32'd0, 5'd0, 5'd0, 5'd7, 1'b1);
    #1;
    chk("x0_stall", stall_if_id, 32'd0);
    tick();
    chk("x0_pc", pc_ex, 32'h110);
    chk("x0_valid", valid_ex, 32'd1);
    chk("x0_bc", bubble_count, bc_exp(bubbles));

    // Invalid ID slot loads with ctrl forced to zero
    drive(C_ADDI, 3'd1, 32'h114, 32'h0, 32'h0, 32'd3, 5'd2, 5'd3, 5'd4, 1'b0);
    tick();
    chk("inv_ctrl", ctrl_ex, 32'h0);
    chk("inv_valid", valid_ex, 32'd0);
    chk("inv_pc", pc_ex, 32'h114);

    // Flush together with a load-use hazard
    drive(C_LW, 3'd2, 32'h118, 32'h0, 32'h0, 32'd0, 5'd1, 5'd0, 5'd6, 1'b1);
    tick();
    drive(C_ADD, 3'd0, 32'h11C, 32'h0, 32'h0, 32'd0, 5'd6, 5'd1, 5'd7, 1'b1);
    flush = 1'b1;
    #1;
    chk("fl_stall", stall_if_id, 32'd0);
    tick(); bubbles++;
    flush = 1'b0;
    chk("fl_valid", valid_ex, 32'd0);
    chk("fl_ctrl", ctrl_ex, 32'h0);
    chk("fl_pc", pc_ex, 32'h0);
    chk("fl_bc", bubble_count, bc_exp(bubbles));
    tick();
    chk("postfl_ctrl", ctrl_ex, 32'h0200);
    chk("postfl_valid", valid_ex, 32'd1);

    // Hold for three cycles with a pending hazard and changing ID inputs
    drive(C_LW, 3'd2, 32'h120, 32'h0, 32'h0, 32'd8, 5'd1, 5'd0, 5'd6, 1'b1);
    tick();
    hold = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(C_ADD, 3'(i), 32'h200 + 32'(i), 32'(i), 32'(i), 32'(i), 5'd6, 5'd1, 5'(9 + i), 1'b1);
      #1;
      chk("hold_stall", stall_if_id, 32'd0);
      tick();
      chk("hold_ctrl", ctrl_ex, 32'h2290);
      chk("hold_pc", pc_ex, 32'h120);
      chk("hold_imm", imm_ex, 32'd8);
      chk("hold_valid", valid_ex, 32'd1);
      chk("hold_bc", bubble_count, bc_exp(bubbles));
    end
    hold = 1'b0;
    drive(C_ADD, 3'd0, 32'h200, 32'h0, 32'h0, 32'd0, 5'd6, 5'd1, 5'd7, 1'b1);
    #1;
    chk("unhold_stall", stall_if_id, 32'd1);
    tick(); bubbles++;
    chk("unhold_valid", valid_ex, 32'd0);
    chk("unhold_bc", bubble_count, bc_exp(bubbles));
    tick();
    chk("resume_pc", pc_ex, 32'h200);
    chk("resume_rd", rd_addr_ex, 32'd7);
    chk("resume_valid", valid_ex, 32'd1);

    // Reset asserted mid-stall
    drive(C_LW, 3'd2, 32'h300, 32'h0, 32'h0, 32'd0, 5'd1, 5'd0, 5'd6, 1'b1);
    tick();
    drive(C_ADD, 3'd0, 32'h304, 32'h0, 32'h0, 32'd0, 5'd1, 5'd6, 5'd7, 1'b1);
    #1;
    chk("pre_rst_stall", stall_if_id, 32'd1);
    #1;
    reset_n = 1'b0;
    #1;
    chk("mrst_ctrl", ctrl_ex, 32'h0);
    chk("mrst_valid", valid_ex, 32'd0);
    chk("mrst_pc", pc_ex, 32'h0);
    chk("mrst_stall", stall_if_id, 32'd0);
    chk("mrst_bc", bubble_count, 32'h0);
    tick();
    reset_n = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
